lbc_sync_multi: RTL
===================

// Module: lbc_sync_multi
// PURPOSE
//  Parametrised LED-board-controller serialiser for TLC5957-style driver chains.
//  On a slice-start pulse it streams one frame of WORDS words to N_CHAINS chains:
//   - one SIN per chain; SCLK and LAT are shared by all chains.
//  Also generates a free-running GCLK.
//  Sits between the frame RAM (read port) and the OutGPIO pins of the display top.
// PARAMETERS
//  N_CHAINS   8   number of parallel driver chains (SIN outputs)
//  WORD_W     48  bits per word per chain, shifted MSB first
//  WORDS      16  words per frame (per chain)
//  SCLK_DIV   2   clk cycles per SCLK half-period (>=1)
//  LAT_WORD   1   SCLK periods LAT is high at the end of a non-final word (WRTGS)
//  LAT_FRAME  3   SCLK periods LAT is high at the end of the final word (LATGS)
//  GCLK_DIV   1   clk cycles per GCLK half-period (>=1)
// PORTS
//  clk      in   1                 system clock
//  nrst     in   1                 asynchronous active-low reset
//  sync     in   1                 1-cycle frame start request
//  ovr_clr  in   1                 clears overrun
//  gclk_en  in   1                 enables GCLK toggling
//  rd_en    out  1                 frame RAM read strobe
//  rd_addr  out  $clog2(WORDS)     word address
//  rd_data  in   N_CHAINS*WORD_W   chain c = rd_data[c*WORD_W +: WORD_W]; valid 1 clk after rd_en
//  sclk     out  1                 shared shift clock
//  sin      out  N_CHAINS          serial data, one bit per chain
//  lat      out  1                 shared latch
//  gclk     out  1                 grayscale clock
//  busy     out  1                 frame in progress
//  done     out  1                 1-cycle pulse at end of frame
//  overrun  out  1                 sticky: sync arrived while busy
// BEHAVIOUR
//  Reset (nrst=0, async): all outputs 0, state IDLE, word counter 0, shift regs 0.
//  FSM IDLE -> FETCH -> LOAD -> SHIFT -> (FETCH | FIN) -> IDLE.
//  IDLE:
//   - sclk=lat=0, sin=0.
//   - sync=1 at edge k: rd_en=1, rd_addr=0 and busy=1 from edge k+1; -> FETCH.
//  FETCH:
//   - 1 cycle; rd_en drops, then -> LOAD.
//  LOAD:
//   - 1 cycle; shift regs capture rd_data; -> SHIFT.
//  SHIFT:
//   - Bit period = 2*SCLK_DIV clk: sclk low SCLK_DIV cycles, then high SCLK_DIV cycles.
//   - sin changes only at the start of the low phase.
//   - MSB is on sin from the first SHIFT cycle.
//   - First sclk rise is at edge k+3+SCLK_DIV.
//   - L = (word==WORDS-1) ? LAT_FRAME : LAT_WORD.
//   - lat rises at the start of bit WORD_W-L's low phase (bits numbered 0..WORD_W-1 in shift order).
//   - lat falls together with the final sclk fall, so it is high for exactly L rising sclk edges.
//  Word end:
//   - if word<WORDS-1: rd_addr+1, rd_en=1, -> FETCH.
//   - Inter-word gap = 2 clk with sclk=lat=0; sin holds the last bit.
//  Last word end:
//   - FIN: done=1 for 1 clk, busy=0 at the same edge, sin=0 -> IDLE.
//   - sync accepted again on the next cycle.
//  Frame length:
//   - WORDS*(2*SCLK_DIV*WORD_W+2) clk from the first rd_en to the done pulse.
//  sync while busy:
//   - ignored; overrun=1 on the next edge.
//   - overrun holds until ovr_clr=1 or reset.
//   - same-cycle set and clear: set wins.
//  GCLK:
//   - free-running, toggles every GCLK_DIV clk while gclk_en=1.
//   - gclk_en=0 holds the current level; independent of the FSM.
//  Reset mid-frame: outputs drop to 0 immediately; no partial done pulse.
//  Word counter is $clog2(WORDS) bits and never exceeds WORDS-1.
//  Elaboration error if LAT_FRAME>WORD_W, LAT_WORD>WORD_W, SCLK_DIV<1 or GCLK_DIV<1.
// TESTING
//  Bench config: N_CHAINS=2, WORD_W=8, WORDS=2, SCLK_DIV=2, LAT_WORD=1, LAT_FRAME=3.
//  1. Word 0 = {8'hA5, 8'h3C}, word 1 = {8'hFF, 8'h01}; sync
//     -> sin[1] sees 10100101 then 11111111; sin[0] sees 00111100 then 00000001.
//     -> 16 sclk rises; done after 2*(32+2) = 68 clk from the first rd_en.
//  2. Same frame
//     -> lat high for 1 sclk rise at the end of word 0 and 3 rises at the end of word 1.
//     -> sclk and lat are low in the 2-clk gap.
//  3. sync pulsed 10 clk into a frame
//     -> frame unaffected, overrun=1.
//     -> ovr_clr and sync in the same cycle while busy: overrun stays 1; ovr_clr alone: 0.
//  4. nrst pulled low mid-word 1
//     -> sclk/lat/sin/busy/done = 0 immediately, no done pulse.
//     -> a new sync restarts at rd_addr=0.
//  5. sync on the cycle after done
//     -> accepted; busy high again on the next edge, rd_addr=0.
//  6. GCLK_DIV=1, gclk_en=1 for 6 clk, then 0
//     -> gclk toggles every clk (3 periods), then holds its level.

Source files
------------

// File: rtl/lbc_sync_multi.sv
// Purpose: serialises one frame of WORDS words onto N_CHAINS TLC5957-style SIN lines (shared SCLK/LAT) and runs a free GCLK.
// Latency: rd_en one cycle after sync; first sclk rise SCLK_DIV+2 cycles after rd_en; done WORDS*(2*SCLK_DIV*WORD_W+2) cycles after rd_en.
// Backpressure: none; sync while busy is dropped and recorded on the sticky overrun flag.
//
// Ports:
//   clk, nrst          system clock, asynchronous active-low reset
//   sync               1-cycle frame start request
//   ovr_clr            clears overrun (a same-cycle overrun set wins)
//   gclk_en            lets gclk toggle; low holds the current level
//   rd_en, rd_addr     frame RAM read strobe/word address; rd_data valid 1 clk after rd_en
//   rd_data            chain c = rd_data[c*WORD_W +: WORD_W]
//   sclk, sin, lat     shared shift clock, per-chain serial data (MSB first), shared latch
//   gclk               grayscale clock
//   busy, done         frame in progress, 1-cycle end-of-frame pulse
//   overrun            sticky: sync arrived while busy
`timescale 1ns/1ps
module lbc_sync_multi #(
  parameter int N_CHAINS  = 8,
  parameter int WORD_W    = 48,
  parameter int WORDS     = 16,
  parameter int SCLK_DIV  = 2,
  parameter int LAT_WORD  = 1,
  parameter int LAT_FRAME = 3,
  parameter int GCLK_DIV  = 1,
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         sync,
  input  logic                         ovr_clr,
  input  logic                         gclk_en,
  output logic                         rd_en,
  output logic [AW-1:0]                rd_addr,
  input  logic [N_CHAINS*WORD_W-1:0]   rd_data,
  output logic                         sclk,
  output logic [N_CHAINS-1:0]          sin,
  output logic                         lat,
  output logic                         gclk,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int GW = (GCLK_DIV > 1) ? $clog2(GCLK_DIV) : 1;
  // Index of the first bit whose low phase starts with lat high.
  localparam int LS_WORD  = WORD_W - LAT_WORD;
  localparam int LS_FRAME = WORD_W - LAT_FRAME;

  if (LAT_FRAME > WORD_W || LAT_WORD > WORD_W || SCLK_DIV < 1 || GCLK_DIV < 1) begin : g_bad_param
    $error("lbc_sync_multi: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_FIN} state_t;

  state_t                      state, state_nxt;
  logic [DW-1:0]               div_cnt, div_nxt;
  logic                        phase_hi, phase_nxt;
  logic [BW-1:0]               bit_cnt, bit_nxt;
  logic [AW-1:0]               word, word_nxt;
  logic [N_CHAINS*WORD_W-1:0]  shreg, shreg_nxt;
  logic                        sclk_nxt, lat_nxt, rd_en_nxt, busy_nxt, done_nxt;
  logic                        last_word;
  int                          lat_start;
  logic [GW-1:0]               gclk_cnt;

  assign last_word = (word == AW'(WORDS - 1));
  assign lat_start = last_word ? LS_FRAME : LS_WORD;
  assign rd_addr   = word;

  always_comb begin
    sin = '0;
    for (int c = 0; c < N_CHAINS; c++) sin[c] = shreg[c*WORD_W + WORD_W - 1];
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    phase_nxt = phase_hi;
    bit_nxt   = bit_cnt;
    word_nxt  = word;
    shreg_nxt = shreg;
    sclk_nxt  = sclk;
    lat_nxt   = lat;
    rd_en_nxt = 1'b0;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      // FIN is the done cycle; it already counts as idle, so sync is taken here too.
      S_IDLE, S_FIN: begin
        state_nxt = S_IDLE;
        sclk_nxt  = 1'b0;
        lat_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        shreg_nxt = '0;
        if (sync) begin
          state_nxt = S_FETCH;
          word_nxt  = '0;
          rd_en_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        state_nxt = S_SHIFT;
        shreg_nxt = rd_data;
        div_nxt   = '0;
        phase_nxt = 1'b0;
        bit_nxt   = '0;
        sclk_nxt  = 1'b0;
        lat_nxt   = (lat_start == 0);
      end
      S_SHIFT: begin
        if (div_cnt != DW'(SCLK_DIV - 1)) begin
          div_nxt = div_cnt + 1'b1;
        end else begin
          div_nxt = '0;
          if (!phase_hi) begin
            phase_nxt = 1'b1;
            sclk_nxt  = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            sclk_nxt  = 1'b0;
            if (bit_cnt == BW'(WORD_W - 1)) begin
              // Word end: lat falls with the last sclk fall; sin keeps the last bit through the gap.
              lat_nxt = 1'b0;
              bit_nxt = '0;
              if (last_word) begin
                state_nxt = S_FIN;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                shreg_nxt = '0;
              end else begin
                state_nxt = S_FETCH;
                word_nxt  = word + 1'b1;
                rd_en_nxt = 1'b1;
              end
            end else begin
              bit_nxt = bit_cnt + 1'b1;
              lat_nxt = ((int'(bit_cnt) + 1) >= lat_start);
              for (int c = 0; c < N_CHAINS; c++)
                shreg_nxt[c*WORD_W +: WORD_W] = shreg[c*WORD_W +: WORD_W] << 1;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      phase_hi <= 1'b0;
      bit_cnt  <= '0;
      word     <= '0;
      shreg    <= '0;
      sclk     <= 1'b0;
      lat      <= 1'b0;
      rd_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      phase_hi <= phase_nxt;
      bit_cnt  <= bit_nxt;
      word     <= word_nxt;
      shreg    <= shreg_nxt;
      sclk     <= sclk_nxt;
      lat      <= lat_nxt;
      rd_en    <= rd_en_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // A set in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)              overrun <= 1'b0;
    else if (sync && busy)  overrun <= 1'b1;
    else if (ovr_clr)       overrun <= 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gclk_cnt <= '0;
      gclk     <= 1'b0;
    end else if (gclk_en) begin
      if (gclk_cnt == GW'(GCLK_DIV - 1)) begin
        gclk_cnt <= '0;
        gclk     <= ~gclk;
      end else begin
        gclk_cnt <= gclk_cnt + 1'b1;
      end
    end
  end

endmodule
